// File: rtl/prog_sequencer.sv
// Program sequencer: the host loads 16-bit instructions a byte at a time, and the
// block replays them into the core one per cycle, with stall, stop and looping.
module prog_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_byte,
  input  logic          clear,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic          hold,
  output logic          issue_valid,
  output logic [15:0]   issue_inst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] prog_len,
  output logic [7:0]    loop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          issue_valid_q, issue_valid_d;
  logic [15:0]   issue_inst_q, issue_inst_d;
  logic          err_q, err_d;
  logic [LW-1:0] prog_len_q, prog_len_d;
  logic [7:0]    loop_cnt_q, loop_cnt_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          hi_q, hi_d;
  logic [7:0]    low_q, low_d;

  logic [15:0]   mem [DEPTH];
  logic          mem_we;
  logic          last_slot;

  assign last_slot = ({1'b0, pc_q} == (prog_len_q - LW'(1)));

  always_comb begin
    state_d       = state_q;
    issue_valid_d = issue_valid_q;
    issue_inst_d  = issue_inst_q;
    err_d         = err_q;
    prog_len_d    = prog_len_q;
    loop_cnt_d    = loop_cnt_q;
    pc_d          = pc_q;
    hi_d          = hi_q;
    low_d         = low_q;
    mem_we        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (wr_en) begin
          err_d = 1'b1;
        end
        if (stop) begin
          state_d       = ST_IDLE;
          issue_valid_d = 1'b0;
          pc_d          = '0;
        end else if (hold) begin
          issue_valid_d = 1'b0;
        end else begin
          issue_valid_d = 1'b1;
          issue_inst_d  = mem[pc_q];
          if (!last_slot) begin
            pc_d = pc_q + AW'(1);
          end else if (loop_en) begin
            pc_d       = '0;
            loop_cnt_d = loop_cnt_q + 8'd1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      default: begin
        issue_valid_d = 1'b0;
        // Loading is only legal while idle; a full program drops further bytes.
        if (wr_en) begin
          if (state_q != ST_IDLE || prog_len_q == LW'(DEPTH)) begin
            err_d = 1'b1;
          end else if (!hi_q) begin
            low_d = wr_byte;
            hi_d  = 1'b1;
          end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + LW'(1);
            hi_d       = 1'b0;
          end
        end
        // Start looks at the pre-write length and phase, so it uses the _q values.
        if (clear) begin
          state_d    = ST_IDLE;
          prog_len_d = '0;
          hi_d       = 1'b0;
          err_d      = 1'b0;
          loop_cnt_d = '0;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          if (prog_len_q != '0 && !hi_q) begin
            state_d    = ST_RUN;
            pc_d       = '0;
            loop_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      err_q         <= 1'b0;
      prog_len_q    <= '0;
      loop_cnt_q    <= '0;
      pc_q          <= '0;
      hi_q          <= 1'b0;
      low_q         <= '0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      err_q         <= err_d;
      prog_len_q    <= prog_len_d;
      loop_cnt_q    <= loop_cnt_d;
      pc_q          <= pc_d;
      hi_q          <= hi_d;
      low_q         <= low_d;
    end
  end

  // Program storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_len_q[AW-1:0]] <= {wr_byte, low_q};
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_inst  = issue_inst_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign prog_len    = prog_len_q;
  assign loop_cnt    = loop_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: loading, replay, hold, looping, overflow,
// start errors and asynchronous reset while running.
module tb_prog_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_byte;
  logic        clear;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        hold;
  logic        issue_valid;
  logic [15:0] issue_inst;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  prog_len;
  logic [7:0]  loop_cnt;

  int checks;
  int failures;

  prog_sequencer #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_byte(wr_byte),
    .clear(clear), .start(start), .stop(stop), .loop_en(loop_en), .hold(hold),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .busy(busy),
    .done(done), .err(err), .prog_len(prog_len), .loop_cnt(loop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_byte = w[7:0];
    tick();
    wr_byte = w[15:8];
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    #3;
    got = {issue_valid, issue_inst, busy, done, err, prog_len, loop_cnt};
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h want %h", got, 32'd0);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_run();
    logic [15:0] exp [3] = '{16'h2067, 16'h4A1B, 16'h0003};
    for (int i = 0; i < 3; i++) write_word(exp[i]);
    checks++;
    if (prog_len !== 4'd3) begin
      failures++;
      $display("[TB] FAIL basic_prog_len: got %0d want 3", prog_len);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_start: busy=%b valid=%b want busy=1 valid=0", busy, issue_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (issue_valid !== 1'b1 || issue_inst !== exp[i]) begin
        failures++;
        $display("[TB] FAIL basic_issue%0d: valid=%b inst=%h want valid=1 inst=%h", i, issue_valid, issue_inst, exp[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done: done=%b busy=%b want done=1 busy=0", done, busy);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_after_done: valid=%b done=%b want valid=0 done=1", issue_valid, done);
    end
    pulse_clear();
    checks++;
    if (prog_len !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_clear: prog_len=%0d done=%b want 0 0", prog_len, done);
    end
  endtask

  task automatic test_hold();
    logic [16:0] exp [5] = '{{1'b1, 16'h2067}, {1'b0, 16'h2067}, {1'b0, 16'h2067},
                            {1'b1, 16'h4A1B}, {1'b1, 16'h0003}};
    write_word(16'h2067);
    write_word(16'h4A1B);
    write_word(16'h0003);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      hold = (i == 1 || i == 2);
      tick();
      checks++;
      if ({issue_valid, issue_inst} !== exp[i]) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d: got %h want %h", i, {issue_valid, issue_inst}, exp[i]);
      end
    end
    hold = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_done: got %b want 1", done);
    end
    pulse_clear();
  endtask

  task automatic test_loop();
    logic [15:0] words [2] = '{16'hA001, 16'hB002};
    write_word(words[0]);
    write_word(words[1]);
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (issue_valid !== 1'b1 || issue_inst !== words[i % 2]) begin
        failures++;
        $display("[TB] FAIL loop_issue%0d: valid=%b inst=%h want valid=1 inst=%h", i, issue_valid, issue_inst, words[i % 2]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || loop_cnt !== 8'd3) begin
      failures++;
      $display("[TB] FAIL loop_stop: valid=%b busy=%b done=%b loop_cnt=%0d want 0 0 0 3",
               issue_valid, busy, done, loop_cnt);
    end
    pulse_clear();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) write_word(16'h1000 + 16'(i * 16'h0111));
    checks++;
    if (prog_len !== 4'd8 || err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_len_err: prog_len=%0d err=%b want 8 1", prog_len, err);
    end
    pulse_start();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (issue_inst !== 16'h1777 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_slot7: inst=%h done=%b want 1777 1", issue_inst, done);
    end
    pulse_clear();
    checks++;
    if (prog_len !== 4'd0 || err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow_clear: prog_len=%0d err=%b done=%b want 0 0 0", prog_len, err, done);
    end
  endtask

  task automatic test_start_errors();
    logic seen_valid;
    seen_valid = 1'b0;
    pulse_start();
    seen_valid |= issue_valid;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_empty: err=%b busy=%b want 1 0", err, busy);
    end
    pulse_clear();
    wr_en = 1'b1;
    wr_byte = 8'h55;
    tick();
    wr_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      seen_valid |= issue_valid;
      tick();
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || prog_len !== 4'd0 || seen_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_half_word: err=%b busy=%b prog_len=%0d seen_valid=%b want 1 0 0 0",
               err, busy, prog_len, seen_valid);
    end
    pulse_clear();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] got;
    write_word(16'h2067);
    write_word(16'h4A1B);
    loop_en = 1'b1;
    pulse_start();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    got = {issue_valid, issue_inst, busy, done, err, prog_len, loop_cnt};
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got %h want %h", got, 32'd0);
    end
    #2 rst_n = 1'b1;
    loop_en = 1'b0;
    tick();
    pulse_start();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_then_start: err=%b busy=%b want 1 0", err, busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_byte  = 8'h00;
    clear    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    hold     = 1'b0;
    test_reset();
    test_basic_run();
    test_hold();
    test_loop();
    test_overflow();
    test_start_errors();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
